// File: rtl/led_blink_bank.sv
// Multi-channel LED driver: each channel runs OFF, ON, BLINK or ONESHOT, configured per channel
// through a valid/ready port, with a global sync that re-phases every blinking channel.
module led_blink_bank #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 8,
  parameter int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half,
  output logic                cfg_err,
  input  logic                sync,
  output logic [CHANNELS-1:0] led
);

  typedef enum logic [1:0] {
    ModeOff     = 2'd0,
    ModeOn      = 2'd1,
    ModeBlink   = 2'd2,
    ModeOneshot = 2'd3
  } mode_e;

  mode_e               mode_q [CHANNELS];
  mode_e               mode_d [CHANNELS];
  logic [CNT_W-1:0]    half_q [CHANNELS];
  logic [CNT_W-1:0]    half_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CNT_W-1:0]    last   [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;
  logic                cfg_ready_q;
  logic                cfg_err_q, cfg_err_d;
  logic                accept;

  assign accept    = cfg_valid & cfg_ready_q;
  assign cfg_err_d = accept & (32'(cfg_ch) >= CHANNELS);

  // Terminal count h-1 with h = max(half, 1), so half=0 behaves as half=1.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      last[i] = (half_q[i] == '0) ? '0 : half_q[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= ModeOff;
        half_q[i] <= CNT_W'(DEFAULT_HALF);
        cnt_q[i]  <= '0;
      end
      led_q       <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= mode_d[i];
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      led_q       <= led_d;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      led_d[i]  = led_q[i];
      unique case (mode_q[i])
        ModeOff: begin
          cnt_d[i] = '0;
          led_d[i] = 1'b0;
        end
        ModeOn: begin
          cnt_d[i] = '0;
          led_d[i] = 1'b1;
        end
        ModeBlink: begin
          if (sync) begin
            cnt_d[i] = '0;
            led_d[i] = 1'b1;
          end else if (cnt_q[i] == last[i]) begin
            cnt_d[i] = '0;
            led_d[i] = ~led_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ModeOneshot: begin
          if (cnt_q[i] == last[i]) begin
            cnt_d[i]  = '0;
            led_d[i]  = 1'b0;
            mode_d[i] = ModeOff;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: ;
      endcase
      // A config write overrides any running phase, including a same-cycle sync.
      if (accept && (cfg_ch == CH_W'(i))) begin
        mode_d[i] = mode_e'(cfg_mode);
        half_d[i] = cfg_half;
        cnt_d[i]  = '0;
        led_d[i]  = (cfg_mode != 2'd0);
      end
    end
  end

  assign led       = led_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank: a 4-channel instance for timing/sync and a
// 3-channel instance for out-of-range channel writes.
module tb_led_blink_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync;
  logic       cfg_valid, cfg_ready, cfg_err;
  logic [1:0] cfg_ch, cfg_mode;
  logic [15:0] cfg_half;
  logic [3:0] led;
  logic       cfg_valid_b, cfg_ready_b, cfg_err_b;
  logic [1:0] cfg_ch_b, cfg_mode_b;
  logic [15:0] cfg_half_b;
  logic [2:0] led_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int s0, h0, s1, h1;

  led_blink_bank dut_a (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_err(cfg_err), .sync(sync), .led(led)
  );

  led_blink_bank #(.CHANNELS(3)) dut_b (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .cfg_ch(cfg_ch_b), .cfg_mode(cfg_mode_b), .cfg_half(cfg_half_b), .cfg_err(cfg_err_b),
    .sync(sync), .led(led_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want normal end");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [15:0] half);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_half  = half;
    step();
    cfg_valid = 1'b0;
  endtask

  function automatic logic blink_at(input int s, input int h, input int t);
    int he;
    he = (h == 0) ? 1 : h;
    return (((t - s) / he) % 2) == 0;
  endfunction

  // ch0/ch1 blinking, ch2 finished oneshot (off), ch3 on
  function automatic logic [3:0] exp_vec();
    return {1'b1, 1'b0, blink_at(s1, h1, cyc), blink_at(s0, h0, cyc)};
  endfunction

  task automatic run_vec(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      check_eq(tag, 32'(led), 32'(exp_vec()));
      step();
    end
  endtask

  initial begin
    rst = 1'b0; sync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0;
    cfg_valid_b = 1'b0; cfg_ch_b = '0; cfg_mode_b = '0; cfg_half_b = '0;

    // Reset defaults
    step(); step();
    check_eq("rst_led", 32'(led), 32'h0);
    check_eq("rst_ready", 32'(cfg_ready), 32'h0);
    check_eq("rst_err", 32'(cfg_err), 32'h0);
    rst = 1'b1;
    check_eq("rel_ready_pre", 32'(cfg_ready), 32'h0);
    step();
    check_eq("rel_ready", 32'(cfg_ready), 32'h1);
    check_eq("rel_led", 32'(led), 32'h0);

    // BLINK half=8: 8 lit, 8 dark, four periods
    wr(2'd0, 2'd2, 16'd8);
    for (int k = 0; k < 64; k++) begin
      check_eq("blink8", 32'(led[0]), 32'(((k / 8) % 2) == 0));
      step();
    end
    // half=0 acts as 1: toggles every cycle
    wr(2'd0, 2'd2, 16'd0);
    for (int k = 0; k < 10; k++) begin
      check_eq("blink0", 32'(led[0]), 32'((k % 2) == 0));
      step();
    end
    wr(2'd0, 2'd0, 16'd3);
    check_eq("off0", 32'(led), 32'h0);

    // ONESHOT ch2 half=5 with a sync mid-pulse
    wr(2'd2, 2'd3, 16'd5);
    for (int k = 0; k < 60; k++) begin
      check_eq("oneshot", 32'(led[2]), 32'(k < 5));
      if (k == 2) sync = 1'b1;
      step();
      sync = 1'b0;
    end

    // Independence and sync
    wr(2'd0, 2'd2, 16'd3); s0 = cyc; h0 = 3;
    wr(2'd1, 2'd2, 16'd7); s1 = cyc; h1 = 7;
    wr(2'd3, 2'd1, 16'd0);
    run_vec("indep", 5);
    sync = 1'b1;
    step();
    sync = 1'b0;
    s0 = cyc; s1 = cyc;
    run_vec("sync", 20);
    check_eq("err_a", 32'(cfg_err), 32'h0);
    // Same-cycle write to ch1 and sync
    sync = 1'b1;
    wr(2'd1, 2'd2, 16'd2);
    sync = 1'b0;
    s0 = cyc; s1 = cyc; h1 = 2;
    run_vec("sync_wr", 20);

    // Out-of-range channel on the 3-channel instance
    cfg_valid_b = 1'b1; cfg_ch_b = 2'd1; cfg_mode_b = 2'd1; cfg_half_b = 16'd4;
    step();
    cfg_valid_b = 1'b0;
    check_eq("b_on", 32'(led_b), 32'h2);
    check_eq("b_err_ok", 32'(cfg_err_b), 32'h0);
    cfg_valid_b = 1'b1; cfg_ch_b = 2'd3; cfg_mode_b = 2'd2; cfg_half_b = 16'd1;
    step();
    cfg_valid_b = 1'b0;
    check_eq("b_err", 32'(cfg_err_b), 32'h1);
    check_eq("b_led_hold", 32'(led_b), 32'h2);
    step();
    check_eq("b_err_clr", 32'(cfg_err_b), 32'h0);
    check_eq("b_led_hold2", 32'(led_b), 32'h2);

    // Async reset mid-blink
    wr(2'd0, 2'd2, 16'd4);
    step(); step();
    check_eq("pre_arst", 32'(led[0]), 32'h1);
    #3 rst = 1'b0;
    #1;
    check_eq("arst_led", 32'(led), 32'h0);
    check_eq("arst_led_b", 32'(led_b), 32'h0);
    check_eq("arst_ready", 32'(cfg_ready), 32'h0);
    step();
    rst = 1'b1;
    check_eq("arst_ready_hold", 32'(cfg_ready), 32'h0);
    step();
    check_eq("arst_ready_rel", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 10; k++) begin
      check_eq("post_arst_off", 32'(led), 32'h0);
      step();
    end
    wr(2'd1, 2'd1, 16'd0);
    check_eq("post_arst_on", 32'(led), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
